sha256_compression_ctrl: RTL

//  Sequencer for the SHA-256 compression datapath (round logic with Sigma0/Sigma1, Ch, Maj,

---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_compression_ctrl_if.sv | 31 +++
 rtl/sha256_round_counter.sv | 34 +++
 rtl/sha256_compression_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the compression controller state encoding.
// The datapath also imports this package for the IV constants.
package sha256_pkg;

    localparam int SHA256_NUM_ROUNDS = 64;
    localparam int SHA256_MSG_WORDS  = 16;
    localparam int SHA256_IDX_W      = $clog2(SHA256_NUM_ROUNDS);

    // ST_HV_INIT is the one-cycle slot that gives H time to settle from the IV before load_work.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HV_INIT,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_e;

    localparam logic [31:0] SHA256_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_compression_ctrl_if.sv
// Control and handshake bundle between the bus FSM / datapath (master) and the
// compression sequencer (slave).
interface sha256_compression_ctrl_if;
    import sha256_pkg::*;

    logic                    start;
    logic                    init_hash;
    logic                    msg_valid;
    logic                    msg_ready;
    logic                    busy;
    logic                    hv_init_iv;
    logic                    load_work;
    logic                    round_en;
    logic [SHA256_IDX_W-1:0] round_idx;
    logic                    w_sel_sched;
    logic                    hash_update;
    logic                    done;

    modport master (
        output start, init_hash, msg_valid,
        input  msg_ready, busy, hv_init_iv, load_work, round_en, round_idx,
               w_sel_sched, hash_update, done
    );

    modport slave (
        input  start, init_hash, msg_valid,
        output msg_ready, busy, hv_init_iv, load_work, round_en, round_idx,
               w_sel_sched, hash_update, done
    );

endinterface

// File: rtl/sha256_round_counter.sv
// Round index counter: advances once per executed round, wraps to 0 after the
// last round, and flags the message-input phase (t < 16).
module sha256_round_counter
    import sha256_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    en_i,
    output logic [SHA256_IDX_W-1:0] idx_o,
    output logic                    last_round_o,
    output logic                    msg_phase_o
);

    localparam logic [SHA256_IDX_W-1:0] LAST_IDX  = SHA256_IDX_W'(SHA256_NUM_ROUNDS - 1);
    localparam logic [SHA256_IDX_W-1:0] MSG_LIMIT = SHA256_IDX_W'(SHA256_MSG_WORDS);

    logic [SHA256_IDX_W-1:0] idx_q;

    // NOTE: reset is synchronous, so it is just the first branch of the clocked block;
    // state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            idx_q <= '0;
        end else if (en_i) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    assign idx_o        = idx_q;
    assign last_round_o = (idx_q == LAST_IDX);
    assign msg_phase_o  = (idx_q < MSG_LIMIT);

endmodule

// File: rtl/sha256_compression_ctrl.sv
// SHA-256 compression sequencer: IV load, work-register load, 64 rounds with a
// stallable message phase, then the H += work update and a done pulse.
module sha256_compression_ctrl
    import sha256_pkg::*;
(
    input logic                       clk,
    input logic                       rst_n,
    sha256_compression_ctrl_if.slave  ctrl_if
);

    state_e                  state_q;
    state_e                  state_d;
    logic                    busy_q;
    logic                    hv_init_iv_q;
    logic                    load_work_q;
    logic                    hash_update_q;
    logic                    done_q;
    logic                    start_accept;
    logic                    in_round;
    logic                    round_en;
    logic                    msg_phase;
    logic                    last_round;
    logic [SHA256_IDX_W-1:0] round_idx;

    assign start_accept = (state_q == ST_IDLE) && ctrl_if.start;
    assign in_round     = (state_q == ST_ROUND);
    // Only the message phase waits on the input stream; scheduler rounds never stall.
    assign round_en     = in_round && (!msg_phase || ctrl_if.msg_valid);

    sha256_round_counter u_round_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_accept),
        .en_i         (round_en),
        .idx_o        (round_idx),
        .last_round_o (last_round),
        .msg_phase_o  (msg_phase)
    );

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (ctrl_if.start) state_d = ST_HV_INIT;
            ST_HV_INIT: state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_ROUND;
            ST_ROUND:   if (round_en && last_round) state_d = ST_UPDATE;
            ST_UPDATE:  state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            hv_init_iv_q  <= 1'b0;
            load_work_q   <= 1'b0;
            hash_update_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= state_d inside {ST_HV_INIT, ST_LOAD, ST_ROUND, ST_UPDATE};
            hv_init_iv_q  <= start_accept && ctrl_if.init_hash;
            load_work_q   <= (state_d == ST_LOAD);
            hash_update_q <= (state_d == ST_UPDATE);
            done_q        <= (state_d == ST_DONE);
        end
    end

    assign ctrl_if.busy        = busy_q;
    assign ctrl_if.hv_init_iv  = hv_init_iv_q;
    assign ctrl_if.load_work   = load_work_q;
    assign ctrl_if.hash_update = hash_update_q;
    assign ctrl_if.done        = done_q;
    assign ctrl_if.round_en    = round_en;
    assign ctrl_if.round_idx   = round_idx;
    assign ctrl_if.msg_ready   = in_round && msg_phase;
    assign ctrl_if.w_sel_sched = in_round && !msg_phase;

endmodule
